// File: rtl/dk_sound_mixer.sv
// Time-multiplexed channel mixer: per-channel Q2.6 gain, wide accumulate, 16-bit saturation.
// Define DK_MIXER_DC_BLOCK_EN to add a DC-blocking high-pass stage after saturation.
module dk_sound_mixer #(
    parameter int NUM_CH   = 4,
    parameter int GAIN_W   = 8,
    parameter int DC_SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     I_RSTn,
    input  logic                     audio_clk_en,
    input  logic [NUM_CH*16-1:0]     in,
    input  logic [NUM_CH*GAIN_W-1:0] gain,
    output logic [15:0]              out,
    output logic                     out_valid,
    output logic                     clip,
    output logic                     overrun
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PROD_W = 16 + GAIN_W + 1;
    localparam int ACC_W  = PROD_W + $clog2(NUM_CH);
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

`ifdef DK_MIXER_DC_BLOCK_EN
    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, DCBLK} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;
`endif

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [15:0]       snap_in_q [NUM_CH];
    logic signed [15:0]       snap_in_d [NUM_CH];
    logic [GAIN_W-1:0]        snap_gain_q [NUM_CH];
    logic [GAIN_W-1:0]        snap_gain_d [NUM_CH];
    logic [15:0]              out_q, out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     clip_q, clip_d;
    logic                     overrun_q, overrun_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [15:0]       sat_val;
    logic                     sat_clip;

`ifdef DK_MIXER_DC_BLOCK_EN
    localparam logic signed [19:0] Y_MAX = 20'sd32767;
    localparam logic signed [19:0] Y_MIN = -20'sd32768;

    // x/y history stays 20 bits wide so the filter state never sees clamping.
    logic signed [15:0] x_q, x_d;
    logic               scale_clip_q, scale_clip_d;
    logic signed [19:0] x_prev_q, x_prev_d;
    logic signed [19:0] y_prev_q, y_prev_d;
    logic signed [19:0] dc_y;
    logic signed [15:0] dc_val;
    logic               dc_clip;

    always_comb begin
        dc_y    = 20'(x_q) - x_prev_q + y_prev_q - (y_prev_q >>> DC_SHIFT);
        dc_clip = (dc_y > Y_MAX) || (dc_y < Y_MIN);
        if (dc_y > Y_MAX)      dc_val = 16'h7fff;
        else if (dc_y < Y_MIN) dc_val = 16'h8000;
        else                   dc_val = dc_y[15:0];
    end
`endif

    // Gain is unsigned Q2.6: zero-extend before the signed multiply, drop 6 fraction bits after.
    always_comb begin
        prod     = PROD_W'(snap_in_q[ch_q]) * PROD_W'($signed({1'b0, snap_gain_q[ch_q]}));
        scaled   = acc_q >>> 6;
        sat_clip = (scaled > ACC_MAX) || (scaled < ACC_MIN);
        if (scaled > ACC_MAX)      sat_val = 16'h7fff;
        else if (scaled < ACC_MIN) sat_val = 16'h8000;
        else                       sat_val = scaled[15:0];
    end

    // NOTE: every *_d gets its hold/idle value first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        snap_in_d   = snap_in_q;
        snap_gain_d = snap_gain_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        clip_d      = 1'b0;
        overrun_d   = audio_clk_en && (state_q != IDLE);
`ifdef DK_MIXER_DC_BLOCK_EN
        x_d          = x_q;
        scale_clip_d = scale_clip_q;
        x_prev_d     = x_prev_q;
        y_prev_d     = y_prev_q;
`endif
        case (state_q)
            IDLE: begin
                if (audio_clk_en) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        snap_in_d[k]   = in[16*k +: 16];
                        snap_gain_d[k] = gain[GAIN_W*k +: GAIN_W];
                    end
                    acc_d   = '0;
                    ch_d    = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACC_W'(prod);
                ch_d  = ch_q + CH_W'(1);
                if (ch_q == CH_W'(NUM_CH - 1)) state_d = SCALE;
            end
            SCALE: begin
`ifdef DK_MIXER_DC_BLOCK_EN
                x_d          = sat_val;
                scale_clip_d = sat_clip;
                state_d      = DCBLK;
`else
                out_d       = sat_val;
                clip_d      = sat_clip;
                out_valid_d = 1'b1;
                state_d     = IDLE;
`endif
            end
`ifdef DK_MIXER_DC_BLOCK_EN
            DCBLK: begin
                x_prev_d    = 20'(x_q);
                y_prev_d    = dc_y;
                out_d       = dc_val;
                clip_d      = scale_clip_q | dc_clip;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            acc_q       <= '0;
            // NOTE: snapshot arrays are reset too, so a mid-mix reset leaves no stale sample behind.
            for (int k = 0; k < NUM_CH; k++) begin
                snap_in_q[k]   <= '0;
                snap_gain_q[k] <= '0;
            end
            out_q       <= '0;
            out_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef DK_MIXER_DC_BLOCK_EN
            x_q          <= '0;
            scale_clip_q <= 1'b0;
            x_prev_q     <= '0;
            y_prev_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            snap_in_q   <= snap_in_d;
            snap_gain_q <= snap_gain_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            clip_q      <= clip_d;
            overrun_q   <= overrun_d;
`ifdef DK_MIXER_DC_BLOCK_EN
            x_q          <= x_d;
            scale_clip_q <= scale_clip_d;
            x_prev_q     <= x_prev_d;
            y_prev_q     <= y_prev_d;
`endif
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign clip      = clip_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/dk_sound_mixer.md
# dk_sound_mixer

Time-multiplexed audio mixer that sits directly downstream of the discrete-sound channel generators (walk, jump, stomp, DAC music, etc.). Once per audio sample it takes every channel's 16-bit signed output and applies a per-channel gain. It accumulates the products in a wide accumulator over successive `clk` cycles, then saturates the sum to a single 16-bit signed sample for the audio output path. An optional DC-blocking high-pass stage removes the offset left by unipolar discrete stages.

## Interface
Parameters:
- `NUM_CH`, default 4: number of input channels, range 1–16.
- `GAIN_W`, default 8: gain width in bits; unsigned Q2.6 format, so 64 = unity and the maximum is 255 ≈ 3.98×.
- `DC_SHIFT`, default 8: pole coefficient of the DC blocker, applied as `y >>> DC_SHIFT`. Used only when the DC blocker is compiled in.

Ports:
- `clk`  in  1  system clock.
- `I_RSTn`  in  1  reset, asynchronous, active-low.
- `audio_clk_en`  in  1  one-cycle sample strobe; starts a mix.
- `in`  in  `NUM_CH*16`  packed signed channel samples; channel k occupies `[16k+15:16k]`.
- `gain`  in  `NUM_CH*GAIN_W`  packed unsigned gains; channel k occupies `[GAIN_W*k+GAIN_W-1:GAIN_W*k]`.
- `out`  out  16  signed mixed sample, registered.
- `out_valid`  out  1  one-cycle pulse when `out` updates.
- `clip`  out  1  high for the same cycle as `out_valid` when saturation occurred in that sample.
- `overrun`  out  1  one-cycle pulse when `audio_clk_en` arrives while the mixer is busy.

## Operation
- FSM states: IDLE, ACCUM, SCALE, plus DCBLK when the DC blocker is compiled in.
- IDLE:
  - On `audio_clk_en`: snapshot all `in` and `gain` into internal registers, clear `acc`, set `ch=0`, go to ACCUM.
  - Input changes after the snapshot do not affect the sample in flight.
- ACCUM:
  - Each cycle performs `acc += snap_in[ch] * $signed({1'b0, snap_gain[ch]})` and increments `ch`.
  - When `ch == NUM_CH-1`, the accumulate happens and the FSM moves to SCALE.
  - ACCUM therefore lasts exactly `NUM_CH` cycles.
- `acc` width is `16 + GAIN_W + 1 + clog2(NUM_CH)` bits, so it never overflows.
- SCALE:
  - Compute `s = acc >>> 6` (arithmetic shift, floor rounding).
  - Clamp `s` to [-32768, 32767] and set the clip flag if clamping occurred.
  - Without the DC blocker: register the result to `out`, pulse `out_valid` and `clip`, return to IDLE.
  - With the DC blocker: go to DCBLK.
- DCBLK:
  - Compute `y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT)` in 20 bits, where `x` is the clamped SCALE result.
  - Store `x_prev = x` and `y_prev = y` unclamped, keeping internal state wide.
  - Clamp `y` to 16 bits, OR any clamp into the clip flag, register to `out`, pulse `out_valid` and `clip`, return to IDLE.
- Busy condition: `audio_clk_en` in any state other than IDLE is ignored for mixing. It pulses `overrun` for 1 cycle, and the current mix completes unaffected.
- Reset, asserted at any time including mid-mix:
  - `out=0`, `out_valid=0`, `clip=0`, `overrun=0`.
  - FSM returns to IDLE; `acc`, `ch`, the snapshots, `x_prev` and `y_prev` are cleared.
  - No partial sample is emitted after reset release.

## Timing
- `audio_clk_en` sampled at cycle T means the snapshot is taken at the edge of T.
- ACCUM occupies T+1 … T+NUM_CH.
- `out`/`out_valid` are visible at T+NUM_CH+1 without the DC blocker and at T+NUM_CH+2 with it. For NUM_CH=4 that is T+5 or T+6.
- `audio_clk_en` may assert again at T+NUM_CH+2 (T+NUM_CH+3 with the DC blocker) without overrun.
- System requirement: `CLOCK_RATE/SAMPLE_RATE ≥ NUM_CH+3`. It is comfortably met at 1 MHz / 48 kHz.
- `out` holds its value between `out_valid` pulses.

## Configuration
- Macro `DK_MIXER_DC_BLOCK_EN`.
- Defined: the DCBLK state and its `x_prev`/`y_prev` registers exist; latency is NUM_CH+2 and `DC_SHIFT` is used.
- Undefined: DCBLK and its registers are absent; SCALE writes `out` directly; latency is NUM_CH+1 and `DC_SHIFT` is ignored.

## Test plan
- Macro undefined, NUM_CH=4:
  - ch0=1000 at gain 64, all others 0 → `out=1000`, `out_valid` at T+5, `clip=0`.
  - ch0=1001 at gain 32 → 500; ch0=-1001 at gain 32 → -501 (floor rounding).
- All four channels 20000 at gain 64 → `out=32767`, `clip=1`. Channels 0,1 = -30000 at gain 128 → `out=-32768`, `clip=1`.
- Second `audio_clk_en` at T+2 → `overrun` pulse at T+2, single `out_valid` at T+5 with the original snapshot's result; changing `in` at T+1 has no effect.
- Reset asserted at T+3 mid-ACCUM → all outputs 0 immediately, no `out_valid` after release; the next strobe mixes correctly.
- Macro defined, DC_SHIFT=8, ch0 held at 10000 at gain 64 → successive samples 10000, 9961, 9923, decaying toward 0; first `out_valid` at T+6.
